// File: rtl/cvxif_mem_pkg.sv
// Shared types and exception codes for the CV-X-IF memory responder.
package cvxif_mem_pkg;

  localparam int unsigned CVX_XLEN = 32;
  localparam int unsigned CVX_ID_W = 3;

  // RISC-V mcause exception codes used on the memory response channel
  localparam logic [5:0] LD_ADDR_MISALIGNED = 6'd4;
  localparam logic [5:0] LD_ACCESS_FAULT    = 6'd5;
  localparam logic [5:0] ST_ADDR_MISALIGNED = 6'd6;
  localparam logic [5:0] ST_ACCESS_FAULT    = 6'd7;

  typedef struct packed {
    logic [CVX_XLEN-1:0]   addr;
    logic                  we;
    logic [CVX_XLEN/8-1:0] be;
    logic [CVX_XLEN-1:0]   wdata;
    logic [CVX_ID_W-1:0]   id;
  } pending_req_t;

  typedef struct packed {
    logic [CVX_ID_W-1:0] id;
    logic                we;
  } outstanding_t;

endpackage

// File: rtl/cvxif_mem_if.sv
// CV-X-IF memory request/response/result channel bundle; the coprocessor is master.
interface cvxif_mem_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ID_W = 3
);
  logic              mem_valid;
  logic              mem_ready;
  logic [ID_W-1:0]   mem_id;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_we;
  logic [2:0]        mem_size;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_resp_exc;
  logic [5:0]        mem_resp_exccode;
  logic              mem_result_valid;
  logic [ID_W-1:0]   mem_result_id;
  logic [XLEN-1:0]   mem_result_rdata;
  logic              mem_result_err;

  modport master (
    output mem_valid, mem_id, mem_addr, mem_we, mem_size, mem_be, mem_wdata,
    input  mem_ready, mem_resp_exc, mem_resp_exccode,
           mem_result_valid, mem_result_id, mem_result_rdata, mem_result_err
  );

  modport slave (
    input  mem_valid, mem_id, mem_addr, mem_we, mem_size, mem_be, mem_wdata,
    output mem_ready, mem_resp_exc, mem_resp_exccode,
           mem_result_valid, mem_result_id, mem_result_rdata, mem_result_err
  );
endinterface

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with fall-through head; push and pop may coincide even when full.
module fifo_v3 import cvxif_mem_pkg::*; #(
  parameter int unsigned DEPTH  = 4,
  parameter type         dtype  = outstanding_t,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  dtype          data_i,
  input  logic          pop_i,
  output dtype          data_o,
  output logic          empty_o,
  output logic [ADDR_W:0] usage_o
);

  dtype              mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // a pop in the same cycle makes room, so a full FIFO still takes the push
  assign do_push = push_i && ((cnt_q != (ADDR_W+1)'(DEPTH)) || do_pop);

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/cvxif_mem_responder.sv
// Core-side CV-X-IF memory responder: checks coprocessor requests, forwards legal ones
// to a req/gnt/rvalid data port and returns in-order results tagged with the request id.
module cvxif_mem_responder import cvxif_mem_pkg::*; #(
  parameter int unsigned     XLEN       = CVX_XLEN,
  parameter int unsigned     ID_W       = CVX_ID_W,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [XLEN-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter logic [XLEN-1:0] SIZE_BYTES = 32'h0010_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cvxif_mem_if.slave        xif,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic              dmem_we_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  input  logic              dmem_err_i,
  output logic              busy_o,
  output logic              protocol_err_o
);

  localparam int unsigned     SZ_MAX    = $clog2(XLEN/8);
  localparam int unsigned     CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [XLEN:0]   LO_BOUND  = {1'b0, BASE_ADDR};
  localparam logic [XLEN:0]   HI_BOUND  = LO_BOUND + {1'b0, SIZE_BYTES};
  localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(XLEN/8 - 1));

  pending_req_t     pend_q;
  logic             pend_v_q;
  logic             perr_q;
  outstanding_t     head;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_usage;
  logic [CNT_W-1:0] cnt;
  logic             ready, accept, grant, pop, send;
  logic             exc;
  logic [5:0]       exccode;
  logic [XLEN-1:0]  lsb_mask;
  logic [XLEN:0]    addr_ext;

  assign cnt    = fifo_usage + CNT_W'(pend_v_q);
  // ready looks only at registered occupancy; a pop this cycle frees nothing yet
  assign ready  = !rst_i && (cnt < CNT_W'(DEPTH)) && (!pend_v_q || dmem_gnt_i);
  assign accept = xif.mem_valid && ready;
  assign grant  = !rst_i && pend_v_q && dmem_gnt_i;
  assign pop    = !rst_i && dmem_rvalid_i && !fifo_empty;

  assign lsb_mask = (XLEN'(1) << xif.mem_size) - XLEN'(1);
  assign addr_ext = {1'b0, xif.mem_addr};

  always_comb begin
    exc     = 1'b1;
    exccode = '0;
    if (xif.mem_size > 3'(SZ_MAX))
      exccode = xif.mem_we ? ST_ACCESS_FAULT : LD_ACCESS_FAULT;
    else if ((xif.mem_addr & lsb_mask) != '0)
      exccode = xif.mem_we ? ST_ADDR_MISALIGNED : LD_ADDR_MISALIGNED;
    else if ((addr_ext < LO_BOUND) || (addr_ext >= HI_BOUND))
      exccode = xif.mem_we ? ST_ACCESS_FAULT : LD_ACCESS_FAULT;
    else
      exc = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      perr_q   <= 1'b0;
    end else begin
      // a new request overwrites the one being granted this cycle: no bubble
      if (accept && !exc) begin
        pend_v_q <= 1'b1;
        pend_q   <= '{addr: xif.mem_addr, we: xif.mem_we, be: xif.mem_be,
                      wdata: xif.mem_wdata, id: xif.mem_id};
      end else if (grant) begin
        pend_v_q <= 1'b0;
      end
      if (dmem_rvalid_i && fifo_empty) perr_q <= 1'b1;
    end
  end

  fifo_v3 #(
    .DEPTH (DEPTH),
    .dtype (outstanding_t)
  ) i_outstanding (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .data_i  ('{id: pend_q.id, we: pend_q.we}),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  assign xif.mem_ready        = ready;
  assign xif.mem_resp_exc     = accept && exc;
  assign xif.mem_resp_exccode = (accept && exc) ? exccode : '0;

  assign xif.mem_result_valid = pop;
  assign xif.mem_result_id    = pop ? head.id : '0;
  assign xif.mem_result_rdata = (pop && !head.we) ? dmem_rdata_i : '0;
  assign xif.mem_result_err   = pop && dmem_err_i;

  assign send         = !rst_i && pend_v_q;
  assign dmem_req_o   = send;
  assign dmem_addr_o  = send ? (pend_q.addr & WORD_MASK) : '0;
  assign dmem_we_o    = send && pend_q.we;
  assign dmem_be_o    = send ? pend_q.be : '0;
  assign dmem_wdata_o = send ? pend_q.wdata : '0;

  assign busy_o         = !rst_i && (cnt != '0);
  assign protocol_err_o = !rst_i && perr_q;

endmodule
